pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Drives per-stage hold (stall) vector consumed by
//  pc_reg, if_id, id_ex, ex_mem, mem_wb; inserts bubbles on load-use hazards; sequences multi-cycle EX ops
//  (div) with an internal countdown; issues single-cycle flush + redirect PC; keeps a stall-cycle perf count.

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the core pipeline sequencing controller:
// stall bit positions, canonical hold vectors and FSM state encoding.
package cpu_ctrl_pkg;

  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB    = 5;
  localparam int STALL_W     = 6;

  // A stage inserts a bubble where its hold bit is 1 and the next stage's is 0.
  localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LOADUSE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MC      = 6'b001111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + PERF_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage hold vector, load-use bubbles,
// multi-cycle EX sequencing, flush/redirect and a stall-cycle perf counter.
module pipe_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_mc_start,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              ex_mc_done,
  output logic              mc_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MC_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  mc_cnt_reg, mc_cnt_next;
  logic [5:0]        stall_next;
  logic              flush_next;
  logic [31:0]       new_pc_next;
  logic              done_next;
  logic [PERF_W-1:0] perf_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      mc_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;
    stall_next  = STALL_NONE;
    flush_next  = 1'b0;
    new_pc_next = 32'h0;
    done_next   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (flush_req) begin
          flush_next  = 1'b1;
          new_pc_next = flush_pc;
        end else if (ex_mc_start) begin
          stall_next  = STALL_MC;
          mc_cnt_next = MC_LAST;
          state_next  = ST_MC_WAIT;
        end else if (stallreq_id) begin
          stall_next = STALL_LOADUSE;
        end
      end
      ST_MC_WAIT: begin
        // New requests are ignored here; the op in EX owns the pipeline until done or flushed.
        if (flush_req) begin
          flush_next  = 1'b1;
          new_pc_next = flush_pc;
          mc_cnt_next = '0;
          state_next  = ST_RUN;
        end else if (mc_cnt_reg == '0) begin
          done_next  = 1'b1;
          state_next = ST_RUN;
        end else begin
          stall_next  = STALL_MC;
          mc_cnt_next = mc_cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next  = ST_RUN;
        mc_cnt_next = '0;
      end
    endcase
  end

  sat_counter #(
    .PERF_W(PERF_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (stall_next != STALL_NONE),
    .count(perf_count)
  );

  assign stall      = rst ? STALL_NONE : stall_next;
  assign flush      = rst ? 1'b0 : flush_next;
  assign new_pc     = rst ? 32'h0 : new_pc_next;
  assign ex_mc_done = rst ? 1'b0 : done_next;
  assign mc_busy    = rst ? 1'b0 : (state_reg == ST_MC_WAIT);
  assign stall_cnt  = rst ? '0 : perf_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of per-cycle vectors against a MC_CYCLES=4
// instance, plus hand sequences for MC_CYCLES=1 and a 4-bit saturating counter.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, stallreq_id, ex_mc_start, flush_req;
  logic [31:0] flush_pc;

  logic [5:0]  stall_a, stall_b, stall_c;
  logic        flush_a, flush_b, flush_c;
  logic [31:0] new_pc_a, new_pc_b, new_pc_c;
  logic        done_a, done_b, done_c;
  logic        busy_a, busy_b, busy_c;
  logic [31:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_CYCLES(4), .CNT_W(6), .PERF_W(32)) u_dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall_a), .flush(flush_a),
    .new_pc(new_pc_a), .ex_mc_done(done_a), .mc_busy(busy_a), .stall_cnt(cnt_a));

  pipe_ctrl #(.MC_CYCLES(1), .CNT_W(6), .PERF_W(32)) u_dut_mc1 (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall_b), .flush(flush_b),
    .new_pc(new_pc_b), .ex_mc_done(done_b), .mc_busy(busy_b), .stall_cnt(cnt_b));

  pipe_ctrl #(.MC_CYCLES(4), .CNT_W(6), .PERF_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall_c), .flush(flush_c),
    .new_pc(new_pc_c), .ex_mc_done(done_c), .mc_busy(busy_c), .stall_cnt(cnt_c));

  typedef struct {
    logic        rst, sreq, mcs, frq;
    logic [31:0] fpc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_done, e_busy;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SL = 6'b000111;
  localparam logic [5:0] SM = 6'b001111;
  localparam logic [31:0] PC_A = 32'hBFC0_0100;
  localparam logic [31:0] PC_B = 32'h0000_1234;

  function automatic vec_t mk(logic r, logic s, logic m, logic f, logic [31:0] p,
                              logic [5:0] es, logic ef, logic [31:0] ep,
                              logic ed, logic eb, logic [31:0] ec);
    vec_t v;
    v.rst = r; v.sreq = s; v.mcs = m; v.frq = f; v.fpc = p;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_done = ed; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic m, input logic f, input logic [31:0] p);
    rst = r; stallreq_id = s; ex_mc_start = m; flush_req = f; flush_pc = p;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // rst  sreq mcs  frq  flush_pc       stall flush new_pc done busy cnt
    vq.push_back(mk(1, 1, 1, 1, 32'hFFFF_FFFF, S0, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 32'hFFFF_FFFF, S0, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1, 1, 32'hFFFF_FFFF, S0, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 32'h0, SL, 0, 32'h0, 0, 0, 0));   // load-use
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 0, 32'h0, SM, 0, 32'h0, 0, 0, 1));   // MC start T
    vq.push_back(mk(0, 0, 0, 0, 32'h0, SM, 0, 32'h0, 0, 1, 2));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, SM, 0, 32'h0, 0, 1, 3));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, SM, 0, 32'h0, 0, 1, 4));
    vq.push_back(mk(0, 0, 1, 0, 32'h0, S0, 0, 32'h0, 1, 1, 5));   // done, start ignored
    vq.push_back(mk(0, 0, 1, 0, 32'h0, SM, 0, 32'h0, 0, 0, 5));   // new op T
    vq.push_back(mk(0, 0, 0, 0, 32'h0, SM, 0, 32'h0, 0, 1, 6));
    vq.push_back(mk(0, 0, 0, 1, PC_A,  S0, 1, PC_A,  0, 1, 7));   // flush at T+2
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0, 0, 7));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0, 0, 7));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0, 0, 7));
    vq.push_back(mk(0, 1, 1, 1, PC_B,  S0, 1, PC_B,  0, 0, 7));   // flush beats all
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0, 0, 7));
    vq.push_back(mk(0, 1, 1, 0, 32'h0, SM, 0, 32'h0, 0, 0, 7));   // MC beats load-use
    vq.push_back(mk(0, 1, 1, 0, 32'h0, SM, 0, 32'h0, 0, 1, 8));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, SM, 0, 32'h0, 0, 1, 9));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, SM, 0, 32'h0, 0, 1, 10));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 1, 1, 11));
    vq.push_back(mk(0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0, 0, 11));

    next_cycle();
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].sreq, vq[i].mcs, vq[i].frq, vq[i].fpc);
      @(negedge clk);
      $display("vec %0d: stall=%b flush=%b new_pc=%h done=%b busy=%b cnt=%0d",
               i, stall_a, flush_a, new_pc_a, done_a, busy_a, cnt_a);
      check("stall", i, 64'(stall_a), 64'(vq[i].e_stall));
      check("flush", i, 64'(flush_a), 64'(vq[i].e_flush));
      check("new_pc", i, 64'(new_pc_a), 64'(vq[i].e_pc));
      check("ex_mc_done", i, 64'(done_a), 64'(vq[i].e_done));
      check("mc_busy", i, 64'(busy_a), 64'(vq[i].e_busy));
      check("stall_cnt", i, 64'(cnt_a), 64'(vq[i].e_cnt));
      next_cycle();
    end

    // MC_CYCLES=1: done one cycle after start
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    $display("mc1 T: stall=%b done=%b busy=%b", stall_b, done_b, busy_b);
    check("mc1_stall_T", 0, 64'(stall_b), 64'(SM));
    check("mc1_done_T", 0, 64'(done_b), 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    $display("mc1 T+1: stall=%b done=%b busy=%b", stall_b, done_b, busy_b);
    check("mc1_stall_T1", 1, 64'(stall_b), 64'(S0));
    check("mc1_done_T1", 1, 64'(done_b), 64'd1);
    check("mc1_busy_T1", 1, 64'(busy_b), 64'd1);
    next_cycle();
    @(negedge clk);
    $display("mc1 T+2: done=%b busy=%b cnt=%0d", done_b, busy_b, cnt_b);
    check("mc1_done_T2", 2, 64'(done_b), 64'd0);
    check("mc1_busy_T2", 2, 64'(busy_b), 64'd0);
    check("mc1_cnt_T2", 2, 64'(cnt_b), 64'd1);
    next_cycle();

    // 4-bit perf counter saturation under 20 load-use cycles
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      $display("sat %0d: stall=%b cnt=%0h", k, stall_c, cnt_c);
      if (k == 0 || k == 14 || k == 15 || k == 19)
        check("sat_cnt", k, 64'(cnt_c), (k < 15) ? 64'(k) : 64'hF);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    $display("sat end: stall=%b cnt=%0h", stall_c, cnt_c);
    check("sat_cnt_final", 20, 64'(cnt_c), 64'hF);
    check("sat_stall_idle", 20, 64'(stall_c), 64'(S0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
